// File: rtl/floo_dst_order_guard_pkg.sv
// floo_dst_order_guard_pkg: shared constants and sizing helpers for the destination order guard.
//   DefaultAxiIdWidth   - default AXI ID width (table depth is 2**AxiIdWidth)
//   DefaultMaxTxnsPerId - default number of outstanding transactions per AXI ID
//   order_cnt_width()   - counter width that can hold 0..max_txns without wrapping
package floo_dst_order_guard_pkg;

    localparam int unsigned DefaultAxiIdWidth   = 4;
    localparam int unsigned DefaultMaxTxnsPerId = 8;

    function automatic int unsigned order_cnt_width(input int unsigned max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/floo_dst_order_guard_entry.sv
// floo_dst_order_guard_entry: one per-AXI-ID outstanding counter plus the destination it is bound to.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   inc_i        - a request on this ID is accepted this cycle
//   dec_i        - a transaction on this ID retires this cycle
//   req_dst_i    - destination of the request currently presented
//   eligible_o   - the presented destination may be issued on this ID
//   busy_o       - counter non-zero
module floo_dst_order_guard_entry
    import floo_dst_order_guard_pkg::*;
#(
    parameter int unsigned MaxTxns  = DefaultMaxTxnsPerId,
    parameter int unsigned DstWidth = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic [DstWidth-1:0] req_dst_i,
    output logic                eligible_o,
    output logic                busy_o
);

    localparam int unsigned CntWidth = order_cnt_width(MaxTxns);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxns);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [DstWidth-1:0] dst_q, dst_d;

    // Eligibility looks only at registered state, so retire never reaches ready combinationally.
    assign eligible_o = (cnt_q == '0) || ((dst_q == req_dst_i) && (cnt_q < MaxCnt));
    assign busy_o     = (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        dst_d = inc_i ? req_dst_i : dst_q;
        if (inc_i && !dec_i && cnt_q != MaxCnt)
            cnt_d = cnt_q + CntWidth'(1);
        else if (dec_i && !inc_i && cnt_q != '0)
            cnt_d = cnt_q - CntWidth'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            dst_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dst_q <= dst_d;
        end
    end

    // A retire with nothing outstanding is a protocol violation upstream; it is reported but tolerated.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(dec_i && cnt_q == '0))
                else $warning("order guard: retire on AXI ID with no outstanding transaction");
            assert (!(inc_i && cnt_q == MaxCnt))
                else $error("order guard: accept on saturated AXI ID counter");
        end
    end

endmodule

// File: rtl/floo_dst_order_guard.sv
// floo_dst_order_guard: holds back requests that would send an AXI ID to a new destination while
// older transactions on that ID are still outstanding, keeping per-ID responses in order.
//   clk_i, rst_i                      - clock, asynchronous active-high reset
//   req_valid_i/req_ready_o           - request handshake
//   req_axi_id_i/dst_id_i/payload_i   - request fields (destination already translated)
//   out_valid_o/out_ready_i           - registered output handshake
//   out_axi_id_o/dst_id_o/payload_o   - registered request fields
//   retire_valid_i/retire_axi_id_i    - one transaction on that ID has completed
//   busy_o                            - some AXI ID has outstanding transactions
module floo_dst_order_guard
    import floo_dst_order_guard_pkg::*;
#(
    parameter int unsigned AxiIdWidth   = DefaultAxiIdWidth,
    parameter int unsigned MaxTxnsPerId = DefaultMaxTxnsPerId,
    parameter type         id_t         = logic,
    parameter type         payload_t    = logic
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [AxiIdWidth-1:0]         req_axi_id_i,
    input  logic [$bits(id_t)-1:0]        req_dst_id_i,
    input  logic [$bits(payload_t)-1:0]   req_payload_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [AxiIdWidth-1:0]         out_axi_id_o,
    output logic [$bits(id_t)-1:0]        out_dst_id_o,
    output logic [$bits(payload_t)-1:0]   out_payload_o,
    input  logic                          retire_valid_i,
    input  logic [AxiIdWidth-1:0]         retire_axi_id_i,
    output logic                          busy_o
);

    localparam int unsigned NumIds   = 2 ** AxiIdWidth;
    localparam int unsigned DstWidth = $bits(id_t);
    localparam int unsigned PlWidth  = $bits(payload_t);

    logic [NumIds-1:0]     inc, dec, eligible, busy;
    logic                  accept;
    logic                  out_valid_q, out_valid_d;
    logic [AxiIdWidth-1:0] out_axi_id_q, out_axi_id_d;
    logic [DstWidth-1:0]   out_dst_id_q, out_dst_id_d;
    logic [PlWidth-1:0]    out_payload_q, out_payload_d;

    // The output slot frees up in the same cycle it drains, giving one request per cycle.
    assign req_ready_o = eligible[req_axi_id_i] && (!out_valid_q || out_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    for (genvar i = 0; i < NumIds; i++) begin : gen_entry
        assign inc[i] = accept && (req_axi_id_i == AxiIdWidth'(i));
        assign dec[i] = retire_valid_i && (retire_axi_id_i == AxiIdWidth'(i));
        floo_dst_order_guard_entry #(
            .MaxTxns  (MaxTxnsPerId),
            .DstWidth (DstWidth)
        ) u_entry (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .inc_i      (inc[i]),
            .dec_i      (dec[i]),
            .req_dst_i  (req_dst_id_i),
            .eligible_o (eligible[i]),
            .busy_o     (busy[i])
        );
    end

    assign busy_o = |busy;

    always_comb begin
        out_valid_d   = accept || (out_valid_q && !out_ready_i);
        out_axi_id_d  = accept ? req_axi_id_i  : out_axi_id_q;
        out_dst_id_d  = accept ? req_dst_id_i  : out_dst_id_q;
        out_payload_d = accept ? req_payload_i : out_payload_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q   <= 1'b0;
            out_axi_id_q  <= '0;
            out_dst_id_q  <= '0;
            out_payload_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_axi_id_q  <= out_axi_id_d;
            out_dst_id_q  <= out_dst_id_d;
            out_payload_q <= out_payload_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_axi_id_o  = out_axi_id_q;
    assign out_dst_id_o  = out_dst_id_q;
    assign out_payload_o = out_payload_q;

endmodule

// File: tb/tb_floo_dst_order_guard.sv
// tb_floo_dst_order_guard: directed self-checking bench for floo_dst_order_guard.
module tb_floo_dst_order_guard;

    typedef logic [3:0] dst_t;
    typedef logic [7:0] pl_t;

    logic       clk, rst;
    logic       req_valid, req_ready;
    logic [3:0] req_axi_id;
    logic [3:0] req_dst_id;
    logic [7:0] req_payload;
    logic       out_valid, out_ready;
    logic [3:0] out_axi_id;
    logic [3:0] out_dst_id;
    logic [7:0] out_payload;
    logic       retire_valid;
    logic [3:0] retire_axi_id;
    logic       busy;

    floo_dst_order_guard #(
        .AxiIdWidth   (4),
        .MaxTxnsPerId (8),
        .id_t         (dst_t),
        .payload_t    (pl_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_axi_id_i    (req_axi_id),
        .req_dst_id_i    (req_dst_id),
        .req_payload_i   (req_payload),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_axi_id_o    (out_axi_id),
        .out_dst_id_o    (out_dst_id),
        .out_payload_o   (out_payload),
        .retire_valid_i  (retire_valid),
        .retire_axi_id_i (retire_axi_id),
        .busy_o          (busy)
    );

    logic [3:0] cnt_mon [16];
    for (genvar g = 0; g < 16; g++) begin : gen_mon
        assign cnt_mon[g] = dut.gen_entry[g].u_entry.cnt_q;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [3:0] id, input logic [3:0] dst, input logic [7:0] pl);
        req_valid   = v;
        req_axi_id  = id;
        req_dst_id  = dst;
        req_payload = pl;
    endtask

    task automatic set_ret(input logic v, input logic [3:0] id);
        retire_valid  = v;
        retire_axi_id = id;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        set_req(0, 0, 0, 0);
        set_ret(0, 0);
        tick();
        tick();
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst out_payload", out_payload, 0);
        check("rst out_dst", out_dst_id, 0);
        check("rst ready", req_ready, 1);
        rst = 1'b0;
        tick();

        // same destination, back-to-back
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1, 3, 8'h10 + 8'(k));
            #1 check("t2 ready", req_ready, 1);
            tick();
            check("t2 out_valid", out_valid, 1);
            check("t2 out_payload", out_payload, 32'h10 + k);
        end
        set_req(0, 0, 0, 0);
        tick();
        check("t2 out_valid drop", out_valid, 0);
        check("t2 cnt1", cnt_mon[1], 4);
        check("t2 busy", busy, 1);

        // destination conflict
        set_ret(1, 1);
        repeat (3) tick();
        set_ret(0, 0);
        check("t3 cnt1 after retire", cnt_mon[1], 1);
        set_req(1, 1, 7, 8'h30);
        #1 check("t3 blocked", req_ready, 0);
        tick();
        #1 check("t3 still blocked", req_ready, 0);
        set_ret(1, 1);
        #1 check("t3 retire cycle ready", req_ready, 0);
        tick();
        set_ret(0, 0);
        #1 check("t3 ready after retire", req_ready, 1);
        tick();
        check("t3 out_dst", out_dst_id, 7);
        check("t3 out_payload", out_payload, 8'h30);
        check("t3 cnt1", cnt_mon[1], 1);
        set_req(1, 0, 1, 8'h31);
        #1 check("t3 queued id0 ready", req_ready, 1);
        tick();
        check("t3 id0 out_axi_id", out_axi_id, 0);
        check("t3 id0 out_payload", out_payload, 8'h31);
        set_req(0, 0, 0, 0);
        set_ret(1, 1);
        tick();
        set_ret(1, 0);
        tick();
        set_ret(0, 0);
        check("t3 drained busy", busy, 0);

        // saturation
        for (int k = 0; k < 8; k++) begin
            set_req(1, 4, 2, 8'h40 + 8'(k));
            #1 check("t4 fill ready", req_ready, 1);
            tick();
        end
        check("t4 cnt4 full", cnt_mon[4], 8);
        set_req(1, 4, 2, 8'h48);
        #1 check("t4 9th stalls", req_ready, 0);
        tick();
        #1 check("t4 9th still stalls", req_ready, 0);
        set_ret(1, 4);
        #1 check("t4 pre-retire ready", req_ready, 0);
        tick();
        check("t4 cnt4 after retire", cnt_mon[4], 7);
        #1 check("t4 accept+retire ready", req_ready, 1);
        tick();
        check("t4 cnt4 accept+retire", cnt_mon[4], 7);
        check("t4 out_payload", out_payload, 8'h48);
        set_ret(0, 0);
        set_req(1, 4, 2, 8'h49);
        #1 check("t4 refill ready", req_ready, 1);
        tick();
        check("t4 cnt4 refull", cnt_mon[4], 8);
        set_req(0, 4, 2, 0);
        #1 check("t4 saturated ready", req_ready, 0);
        set_ret(1, 4);
        repeat (8) tick();
        set_ret(0, 0);
        check("t4 cnt4 drained", cnt_mon[4], 0);

        // backpressure
        out_ready = 1'b0;
        set_req(1, 5, 1, 8'hA5);
        #1 check("t5 first ready", req_ready, 1);
        tick();
        set_req(1, 5, 1, 8'h5A);
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t5 hold ready", req_ready, 0);
            check("t5 hold valid", out_valid, 1);
            check("t5 hold payload", out_payload, 8'hA5);
            check("t5 hold axi_id", out_axi_id, 5);
            tick();
        end
        out_ready = 1'b1;
        #1 check("t5 release ready", req_ready, 1);
        tick();
        check("t5 next payload", out_payload, 8'h5A);
        set_req(0, 0, 0, 0);
        tick();
        check("t5 drained valid", out_valid, 0);
        set_ret(1, 5);
        repeat (2) tick();
        set_ret(0, 0);

        // spurious retire, then accept+retire on a busy ID
        set_ret(1, 9);
        tick();
        set_ret(0, 0);
        check("t6 cnt9", cnt_mon[9], 0);
        check("t6 busy", busy, 0);
        set_req(1, 6, 4, 8'h60);
        tick();
        set_req(1, 6, 4, 8'h61);
        tick();
        check("t6 cnt6 two", cnt_mon[6], 2);
        set_req(1, 6, 4, 8'h62);
        set_ret(1, 6);
        #1 check("t6 ready", req_ready, 1);
        tick();
        set_req(0, 0, 0, 0);
        set_ret(0, 0);
        check("t6 cnt6 accept+retire", cnt_mon[6], 2);
        check("t6 out_payload", out_payload, 8'h62);
        set_ret(1, 6);
        repeat (2) tick();
        set_ret(0, 0);
        check("t6 drained busy", busy, 0);

        // reset mid-traffic
        for (int k = 0; k < 3; k++) begin
            set_req(1, 2, 1, 8'h20 + 8'(k));
            tick();
        end
        set_req(0, 0, 0, 0);
        check("t1 cnt2 before", cnt_mon[2], 3);
        check("t1 out_valid before", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("t1 rst out_valid", out_valid, 0);
        check("t1 rst busy", busy, 0);
        check("t1 rst cnt2", cnt_mon[2], 0);
        check("t1 rst out_payload", out_payload, 0);
        tick();
        rst = 1'b0;
        set_req(1, 2, 5, 8'h77);
        #1 check("t1 ready after rst", req_ready, 1);
        tick();
        set_req(0, 0, 0, 0);
        check("t1 out_valid", out_valid, 1);
        check("t1 out_dst", out_dst_id, 5);
        check("t1 cnt2", cnt_mon[2], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
